// File: rtl/credit_pkg.sv
// Shared credit-protocol definitions for debtor- and creditor-side blocks.
// Holds the request FSM state encoding and the saturating-add width helper.
package credit_pkg;

  // Request FSM states. The encoding is stable so a checker can decode it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } credit_state_e;

  // Width needed to hold the sum of a balance and an addend without loss,
  // so overflow shows up as a value above the balance's all-ones maximum.
  function automatic int sat_sum_width(input int bal_w, input int add_w);
    return ((bal_w > add_w) ? bal_w : add_w) + 1;
  endfunction

endpackage

// File: rtl/credit_debtor_fsm.sv
// Borrow-request FSM of the credit debtor: IDLE -> REQ -> WAIT -> IDLE.
// REQ lasts one cycle and is the only cycle with borrow high (registered).
// Optional feature macro: CREDIT_DEBTOR_TIMEOUT_EN adds a WAIT timeout
// counter that re-issues the request after TIMEOUT cycles without a grant.
module credit_debtor_fsm
  import credit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_low,          // next-state balance is at or below the watermark
  input  logic          i_credit_valid, // grant arriving this cycle
  output logic          o_borrow,
  output credit_state_e o_state
);

  credit_state_e r_state;
  logic          r_borrow;

`ifdef CREDIT_DEBTOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  // State register, registered borrow pulse and (optionally) the WAIT timer.
  // The timer expires on the edge where it would count up to TIMEOUT, so a
  // full request period is TIMEOUT cycles in WAIT plus the REQ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_borrow <= 1'b0;
`ifdef CREDIT_DEBTOR_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_borrow <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_low) begin
            r_state  <= REQ;
            r_borrow <= 1'b1;
          end
        end
        REQ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // A grant always wins, including on the timer's expiry cycle.
          if (i_credit_valid) begin
            r_state <= IDLE;
`ifdef CREDIT_DEBTOR_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state  <= REQ;
            r_borrow <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_borrow = r_borrow;
  assign o_state  = r_state;

endmodule

// File: rtl/credit_debtor.sv
// Credit debtor: gates a valid/ready stream with a credit balance and asks
// an upstream creditor for more credit when the balance runs low.
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and both
// directions are forced low while the balance is zero, so the balance can
// never underflow.
//
// Optional feature macro: CREDIT_DEBTOR_TIMEOUT_EN (re-request on timeout,
// implemented in credit_debtor_fsm). dbg_state exposes the FSM state.
module credit_debtor
  import credit_pkg::*;
#(
  parameter int          WIDTH         = 16,
  parameter int          CREDIT_WIDTH  = 8,
  parameter int          DATA_WIDTH    = 16,
  parameter int unsigned LOW_WATERMARK = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CREDIT_WIDTH-1:0] credit,
  input  logic                    credit_valid,
  output logic                    borrow,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        balance,
  output logic                    error,
  output credit_state_e           dbg_state
);

  localparam int SUM_W = sat_sum_width(WIDTH, CREDIT_WIDTH);
  localparam logic [WIDTH-1:0] MAX_BAL = '1;

  logic [WIDTH-1:0] r_balance;
  logic             r_error;

  logic             w_bal_nz;
  logic             w_transfer;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_bal_next;
  logic             w_low;
  logic             w_unsolicited;
  credit_state_e    w_state;

  // Stream gating: data passes straight through, the handshake is qualified
  // by a non-zero balance.
  assign w_bal_nz   = (r_balance != '0);
  assign out_data   = in_data;
  assign out_valid  = in_valid & w_bal_nz;
  assign in_ready   = out_ready & w_bal_nz;
  assign w_transfer = in_valid & out_ready & w_bal_nz;

  // Next balance: add any grant, subtract one per transfer, saturate on overflow.
  // A transfer implies a non-zero balance, so the subtraction cannot wrap.
  always_comb begin
    w_sum      = SUM_W'(r_balance)
               + (credit_valid ? SUM_W'(credit) : SUM_W'(0))
               - SUM_W'(w_transfer);
    w_ovf      = (w_sum > SUM_W'(MAX_BAL));
    w_bal_next = w_ovf ? MAX_BAL : w_sum[WIDTH-1:0];
  end

  assign w_low         = (32'(w_bal_next) <= LOW_WATERMARK);
  assign w_unsolicited = credit_valid & (w_state != WAIT);

  // Balance register and sticky error (overflow or unsolicited grant).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_balance <= '0;
      r_error   <= 1'b0;
    end else begin
      r_balance <= w_bal_next;
      r_error   <= r_error | w_ovf | w_unsolicited;
    end
  end

  credit_debtor_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_low          (w_low),
    .i_credit_valid (credit_valid),
    .o_borrow       (borrow),
    .o_state        (w_state)
  );

  assign balance   = r_balance;
  assign error     = r_error;
  assign dbg_state = w_state;

endmodule

// File: tb/tb_credit_debtor.sv
// Directed bench for credit_debtor. u_dut uses the default widths with
// TIMEOUT=16; u_dut8 uses WIDTH=8 and LOW_WATERMARK=250 so that a solicited
// grant can overflow the balance. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point.
module tb_credit_debtor;
  import credit_pkg::*;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n8;

  // ---------------- main DUT ----------------
  logic [7:0]    credit;
  logic          credit_valid;
  logic          borrow;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   balance;
  logic          error;
  credit_state_e dbg_state;

  credit_debtor #(
    .WIDTH(16), .CREDIT_WIDTH(8), .DATA_WIDTH(16), .LOW_WATERMARK(4), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .credit(credit), .credit_valid(credit_valid),
    .borrow(borrow), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .balance(balance), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- narrow DUT ----------------
  logic [7:0]    c8_credit;
  logic          c8_valid;
  logic          borrow8;
  logic [7:0]    in_data8;
  logic          in_valid8;
  logic          in_ready8;
  logic [7:0]    out_data8;
  logic          out_valid8;
  logic          out_ready8;
  logic [7:0]    balance8;
  logic          error8;
  credit_state_e dbg_state8;

  credit_debtor #(
    .WIDTH(8), .CREDIT_WIDTH(8), .DATA_WIDTH(8), .LOW_WATERMARK(250), .TIMEOUT(16)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .credit(c8_credit), .credit_valid(c8_valid),
    .borrow(borrow8), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .balance(balance8), .error(error8), .dbg_state(dbg_state8)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the number of edges until borrow is seen high, 0 if never.
  task automatic wait_borrow(input bit sel8, input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if ((sel8 ? borrow8 : borrow) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  int n_xfer;
  int n_wait;
  int n_pulse;

  initial begin
    rst_n = 1'b0; rst_n8 = 1'b0;
    credit = '0; credit_valid = 1'b0;
    in_data = 16'hA5C3; in_valid = 1'b1; out_ready = 1'b1;
    c8_credit = '0; c8_valid = 1'b0; in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;

    // Reset state.
    repeat (3) tick();
    check("rst_balance",   balance,   0);
    check("rst_borrow",    borrow,    0);
    check("rst_error",     error,     0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_state",     dbg_state, IDLE);
    check("data_pass_a",   out_data,  16'hA5C3);

    // Release: first edge IDLE -> REQ, borrow high in the second cycle.
    rst_n = 1'b1;
    #2;
    check("rel_borrow_c1", borrow, 0);
    tick();
    check("rel_borrow_c2", borrow,    1);
    check("rel_state_req", dbg_state, REQ);
    check("rel_out_valid", out_valid, 0);
    tick();
    check("req_one_cycle", borrow,    0);
    check("req_to_wait",   dbg_state, WAIT);

    // Grant 8 -> balance 8, then exactly 8 transfers.
    credit = 8'd8; credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("grant8_bal",   balance,   8);
    check("grant8_err",   error,     0);
    check("grant8_state", dbg_state, IDLE);
    check("grant8_ovld",  out_valid, 1);
    in_data = 16'h1234;
    check("data_pass_b",  out_data,  16'h1234);
    n_xfer = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid && out_ready) n_xfer++;
      tick();
    end
    check("drain_xfers", n_xfer,    8);
    check("drain_bal",   balance,   0);
    check("drain_ovld",  out_valid, 0);
    check("drain_irdy",  in_ready,  0);
    check("drain_state", dbg_state, WAIT);

    // Balance 5, one transfer -> 4 and a borrow pulse.
    in_valid = 1'b0;
    credit = 8'd5; credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("bal5",       balance,   5);
    tick();
    check("bal5_idle",  dbg_state, IDLE);
    check("bal5_nobor", borrow,    0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("wm_bal",    balance,   4);
    check("wm_borrow", borrow,    1);
    check("wm_state",  dbg_state, REQ);
    tick();
    check("wm_wait",   dbg_state, WAIT);

    // Grant 10 together with a transfer: 4 + 10 - 1.
    in_valid = 1'b1; credit = 8'd10; credit_valid = 1'b1;
    tick();
    in_valid = 1'b0; credit_valid = 1'b0;
    check("grant_xfer_bal",   balance,   13);
    check("grant_xfer_err",   error,     0);
    check("grant_xfer_state", dbg_state, IDLE);

    // Unsolicited grants in IDLE: still added, error set, FSM stays IDLE.
    tick();
    credit = 8'd7; credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("unsol_bal20", balance,   20);
    check("unsol_err",   error,     1);
    credit = 8'd5; credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("unsol_bal25",  balance,   25);
    check("unsol_err2",   error,     1);
    check("unsol_state",  dbg_state, IDLE);

    // Drain 25 -> 4: borrow on the 21st edge.
    in_valid = 1'b1;
    wait_borrow(1'b0, 64, n_wait);
    in_valid = 1'b0;
    check("drain25_edges", n_wait,  21);
    check("drain25_bal",   balance, 4);

`ifdef CREDIT_DEBTOR_TIMEOUT_EN
    // Re-request 17 cycles after the first pulse.
    wait_borrow(1'b0, 40, n_wait);
    check("timeout_gap", n_wait, 17);
    // Grant on the expiry cycle wins: back to IDLE, no re-pulse.
    repeat (16) tick();
    check("expiry_pre_state", dbg_state, WAIT);
    credit = 8'd50; credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("expiry_state",  dbg_state, IDLE);
    check("expiry_borrow", borrow,    0);
    check("expiry_bal",    balance,   54);
`else
    // Without the timeout, WAIT holds with no re-request.
    n_pulse = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (borrow === 1'b1) n_pulse++;
    end
    check("no_repulse",       n_pulse,   0);
    check("no_repulse_state", dbg_state, WAIT);
    credit = 8'd50; credit_valid = 1'b1;
    tick();
    credit_valid = 1'b0;
    check("late_grant_state", dbg_state, IDLE);
    check("late_grant_bal",   balance,   54);
`endif
    tick();
    check("post_grant_borrow", borrow, 0);

    // Asynchronous reset during a borrow pulse with error set.
    in_valid = 1'b1;
    wait_borrow(1'b0, 80, n_wait);
    check("drain54_edges", n_wait, 50);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_bal",    balance, 0);
    check("arst_err",    error,   0);
    check("arst_borrow", borrow,  0);
    in_valid = 1'b0;

    // Narrow instance: overflow on a solicited grant.
    tick();
    rst_n8 = 1'b1;
    wait_borrow(1'b1, 8, n_wait);
    check("n8_first_req", n_wait, 1);
    tick();
    c8_credit = 8'd250; c8_valid = 1'b1;
    tick();
    c8_valid = 1'b0;
    check("n8_bal250", balance8, 250);
    check("n8_err0",   error8,   0);
    wait_borrow(1'b1, 8, n_wait);
    check("n8_rereq", n_wait, 1);
    tick();
    check("n8_wait", dbg_state8, WAIT);
    c8_credit = 8'd10; c8_valid = 1'b1;
    tick();
    c8_valid = 1'b0;
    check("n8_sat_bal", balance8, 255);
    check("n8_sat_err", error8,   1);
    repeat (20) tick();
    check("n8_hold_bal",    balance8, 255);
    check("n8_hold_err",    error8,   1);
    check("n8_hold_borrow", borrow8,  0);

    // Narrow instance: get to WAIT with balance 7, then reset mid-WAIT.
    rst_n8 = 1'b0;
    #2;
    check("n8_rst_err", error8, 0);
    rst_n8 = 1'b1;
    wait_borrow(1'b1, 8, n_wait);
    check("n8_rel_req", n_wait, 1);
    tick();
    c8_credit = 8'd7; c8_valid = 1'b1;
    tick();
    c8_valid = 1'b0;
    check("n8_bal7", balance8, 7);
    wait_borrow(1'b1, 8, n_wait);
    check("n8_bal7_req", n_wait, 1);
    repeat (2) tick();
    check("n8_mid_wait", dbg_state8, WAIT);
    #3;
    rst_n8 = 1'b0;
    #1;
    check("n8_arst_bal",    balance8,   0);
    check("n8_arst_borrow", borrow8,    0);
    check("n8_arst_state",  dbg_state8, IDLE);
    // Outstanding request discarded: release starts a fresh request.
    #2;
    rst_n8 = 1'b1;
    tick();
    check("n8_fresh_borrow", borrow8,    1);
    check("n8_fresh_state",  dbg_state8, REQ);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/credit_debtor.md
CREDIT_DEBTOR -- requirements
Module: credit_debtor

Interface
REQ-001 Parameter WIDTH, default 16: width of the internal credit balance.
REQ-002 Parameter CREDIT_WIDTH, default 8: width of one credit grant.
REQ-003 Parameter DATA_WIDTH, default 16: width of the gated data stream.
REQ-004 Parameter LOW_WATERMARK, default 4: a borrow is issued when the balance is at or below this value.
REQ-005 Parameter TIMEOUT, default 1024: number of cycles spent waiting for a grant before re-requesting (macro builds only).
REQ-006 clk  input  1  sole clock; all state is updated on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 credit  input  CREDIT_WIDTH  credit value granted by the creditor.
REQ-009 credit_valid  input  1  credit is valid this cycle (single-cycle pulse).
REQ-010 borrow  output  1  registered single-cycle credit request to the creditor.
REQ-011 in_data / in_valid / in_ready  input / input / output  DATA_WIDTH / 1 / 1  upstream stream.
REQ-012 out_data / out_valid / out_ready  output / output / input  DATA_WIDTH / 1 / 1  downstream stream.
REQ-013 balance  output  WIDTH  current credit balance (register value).
REQ-014 error  output  1  sticky protocol-error flag.

Function
REQ-015 out_data SHALL equal in_data combinationally; out_valid = in_valid & (balance != 0); in_ready = out_ready & (balance != 0).
REQ-016 A transfer is a cycle with out_valid & out_ready; each transfer SHALL decrement balance by exactly 1.
REQ-017 On credit_valid, balance SHALL increase by the zero-extended credit in the same edge; when credit_valid and a transfer occur in the same cycle, next balance = balance + credit - 1.
REQ-018 If the sum overflows WIDTH bits, balance SHALL saturate to all-ones and error SHALL be set.
REQ-019 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-020 IDLE -> REQ when the next-state balance <= LOW_WATERMARK; otherwise the FSM stays in IDLE.
REQ-021 REQ SHALL last exactly one cycle, with borrow=1 only in that cycle; REQ -> WAIT unconditionally.
REQ-022 WAIT -> IDLE on credit_valid; a zero-valued grant is legal, and the FSM re-requests from IDLE if the balance is still low.
REQ-023 credit_valid in IDLE or REQ (unsolicited) SHALL still be added to the balance and SHALL set error.
REQ-024 A transfer at balance 0 cannot occur by construction; balance SHALL never underflow.

Reset
REQ-025 While rst_n=0: balance=0, state=IDLE, borrow=0, error=0, and the timeout counter = 0; out_valid and in_ready are 0 because balance=0.
REQ-026 After rst_n deasserts, the first edge SHALL move the FSM IDLE -> REQ, so borrow=1 in the second cycle after release; reset mid-WAIT SHALL discard the outstanding request.
REQ-027 error SHALL clear only on reset.

Configuration
REQ-028 Macro CREDIT_DEBTOR_TIMEOUT_EN: when defined, a counter of width clog2(TIMEOUT+1) SHALL run in WAIT; when it reaches TIMEOUT with no grant, WAIT -> REQ, borrow re-pulses and the counter clears. A grant arriving in the same cycle as expiry SHALL take priority, with WAIT -> IDLE.
REQ-029 When CREDIT_DEBTOR_TIMEOUT_EN is undefined, the counter SHALL be absent, WAIT SHALL persist indefinitely, and TIMEOUT SHALL be ignored.

Structure
REQ-030 The FSM state enum (IDLE/REQ/WAIT) and the saturating-add width helper SHALL live in the shared package credit_pkg, which creditor-side blocks also use.
REQ-031 A single sub-module, credit_debtor_fsm, SHALL hold the state register and timeout counter; the balance datapath and stream gating SHALL stay in credit_debtor.

Verification
REQ-032 Release reset with out_ready=1 and in_valid=1 -> borrow=1 in cycle 2, out_valid=0 until a grant; grant credit=8 -> balance=8 next cycle, and exactly 8 transfers follow.
REQ-033 balance=5, LOW_WATERMARK=4, one transfer -> balance=4 and borrow pulses the following cycle; grant credit=10 in the same cycle as a transfer -> balance=13.
REQ-034 WIDTH=8, balance=250, grant credit=10 -> balance=255 and error=1, with error held after 20 further idle cycles.
REQ-035 credit_valid pulsed while in IDLE with balance=20 -> balance=20+credit, error=1, FSM stays IDLE.
REQ-036 With the macro defined and TIMEOUT=16: no grant -> borrow re-pulses 17 cycles after the first pulse; a grant on the expiry cycle -> no re-pulse and FSM returns to IDLE. Without the macro: no re-pulse within 2000 cycles.
REQ-037 Assert rst_n=0 asynchronously mid-WAIT with balance=7 -> balance, error and borrow read 0 immediately, before the next clock edge.
